// File: rtl/skin_pkg.sv
// Shared types and width helpers for the skin-scan sequencer.
// Tag fields are sized for the largest supported frame; the top narrows them.
package skin_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DRAIN,
        ST_DONE
    } scan_state_t;

    localparam int IMG_W_DEF = 160;
    localparam int IMG_H_DEF = 120;
    localparam int TAG_AW    = 16;
    localparam int TAG_XW    = 12;
    localparam int TAG_YW    = 12;

    typedef struct packed {
        logic              valid;
        logic [TAG_AW-1:0] addr;
        logic [TAG_XW-1:0] x;
        logic [TAG_YW-1:0] y;
    } pix_tag_t;

    function automatic int coord_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_w(input int w, input int h);
        return $clog2(w * h + 1);
    endfunction

endpackage

// File: rtl/skin_scan_ctrl_bbox_accum.sv
// Per-frame skin pixel counter and bounding-box tracker.
// Publishing samples the next-state values so a same-cycle final update is included.
module bbox_accum #(
    parameter int XW = 8,
    parameter int YW = 7,
    parameter int CW = 15
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clr_i,
    input  logic          upd_i,
    input  logic          pub_i,
    input  logic [XW-1:0] x_i,
    input  logic [YW-1:0] y_i,
    output logic [CW-1:0] count_o,
    output logic [XW-1:0] xmin_o,
    output logic [XW-1:0] xmax_o,
    output logic [YW-1:0] ymin_o,
    output logic [YW-1:0] ymax_o,
    output logic          valid_o
);

    logic [CW-1:0] cnt_q, cnt_d, pub_cnt_q;
    logic          hit_q, hit_d, pub_hit_q;
    logic [XW-1:0] xmin_q, xmin_d, xmax_q, xmax_d, pub_xmin_q, pub_xmax_q;
    logic [YW-1:0] ymin_q, ymin_d, ymax_q, ymax_d, pub_ymin_q, pub_ymax_q;

    // Cleared min/max stay zero until the first hit, so a no-skin frame publishes zeros.
    always_comb begin
        cnt_d  = cnt_q;
        hit_d  = hit_q;
        xmin_d = xmin_q;
        xmax_d = xmax_q;
        ymin_d = ymin_q;
        ymax_d = ymax_q;
        if (clr_i) begin
            cnt_d  = '0;
            hit_d  = 1'b0;
            xmin_d = '0;
            xmax_d = '0;
            ymin_d = '0;
            ymax_d = '0;
        end else if (upd_i) begin
            cnt_d = cnt_q + 1'b1;
            hit_d = 1'b1;
            if (!hit_q) begin
                xmin_d = x_i;
                xmax_d = x_i;
                ymin_d = y_i;
                ymax_d = y_i;
            end else begin
                if (x_i < xmin_q) xmin_d = x_i;
                if (x_i > xmax_q) xmax_d = x_i;
                if (y_i < ymin_q) ymin_d = y_i;
                if (y_i > ymax_q) ymax_d = y_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            cnt_q      <= '0;
            hit_q      <= 1'b0;
            xmin_q     <= '0;
            xmax_q     <= '0;
            ymin_q     <= '0;
            ymax_q     <= '0;
            pub_cnt_q  <= '0;
            pub_hit_q  <= 1'b0;
            pub_xmin_q <= '0;
            pub_xmax_q <= '0;
            pub_ymin_q <= '0;
            pub_ymax_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            hit_q  <= hit_d;
            xmin_q <= xmin_d;
            xmax_q <= xmax_d;
            ymin_q <= ymin_d;
            ymax_q <= ymax_d;
            if (pub_i) begin
                pub_cnt_q  <= cnt_d;
                pub_hit_q  <= hit_d;
                pub_xmin_q <= xmin_d;
                pub_xmax_q <= xmax_d;
                pub_ymin_q <= ymin_d;
                pub_ymax_q <= ymax_d;
            end
        end
    end

    assign count_o = pub_cnt_q;
    assign valid_o = pub_hit_q;
    assign xmin_o  = pub_xmin_q;
    assign xmax_o  = pub_xmax_q;
    assign ymin_o  = pub_ymin_q;
    assign ymax_o  = pub_ymax_q;

endmodule

// File: rtl/skin_scan_ctrl.sv
// Raster frame-scan sequencer: feeds SkinDecider one pixel per cycle, writes the
// returned object bit to the mask memory and gathers per-frame skin statistics.
module skin_scan_ctrl
    import skin_pkg::*;
#(
    parameter  int IMG_W   = IMG_W_DEF,
    parameter  int IMG_H   = IMG_H_DEF,
    parameter  int DEC_LAT = 1,
    parameter  int ADDR_W  = 15,
    localparam int XW      = coord_w(IMG_W),
    localparam int YW      = coord_w(IMG_H),
    localparam int CW      = cnt_w(IMG_W, IMG_H)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              bg_diff_en_i,
    input  logic              pause_i,
    output logic              pix_rd_o,
    output logic [ADDR_W-1:0] pix_addr_o,
    input  logic [7:0]        pix_y_i,
    input  logic [7:0]        pix_cb_i,
    input  logic [7:0]        pix_cr_i,
    output logic [7:0]        dec_luma_o,
    output logic [7:0]        dec_cb_o,
    output logic [7:0]        dec_cr_o,
    output logic              dec_bgdiff_o,
    input  logic              dec_obj_i,
    output logic              mask_we_o,
    output logic [ADDR_W-1:0] mask_addr_o,
    output logic              mask_bit_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [CW-1:0]     skin_count_o,
    output logic [XW-1:0]     bbox_xmin_o,
    output logic [XW-1:0]     bbox_xmax_o,
    output logic [YW-1:0]     bbox_ymin_o,
    output logic [YW-1:0]     bbox_ymax_o,
    output logic              bbox_valid_o
);

    localparam int                STAGES    = 2 + DEC_LAT;
    localparam logic [XW-1:0]     X_LAST    = XW'(IMG_W - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(IMG_W * IMG_H - 1);

    scan_state_t       state_q;
    logic [XW-1:0]     x_q;
    logic [YW-1:0]     y_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        luma_q, cb_q, cr_q;
    logic              bgdiff_q, done_q;
    pix_tag_t          tag_q [STAGES];
    logic              issue, upstream_busy, publish, acc_clr, acc_upd;

    assign issue = (state_q == ST_SCAN) && !pause_i;

    // Drain ends once only the write-back stage can still hold a pixel.
    always_comb begin
        upstream_busy = 1'b0;
        for (int i = 0; i < STAGES - 1; i++) upstream_busy = upstream_busy | tag_q[i].valid;
    end

    assign publish = (state_q == ST_DRAIN) && !upstream_busy;
    assign acc_clr = (state_q == ST_IDLE) && start_i;
    assign acc_upd = tag_q[STAGES-1].valid && dec_obj_i;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q  <= ST_IDLE;
            x_q      <= '0;
            y_q      <= '0;
            addr_q   <= '0;
            luma_q   <= '0;
            cb_q     <= '0;
            cr_q     <= '0;
            bgdiff_q <= 1'b0;
            done_q   <= 1'b0;
            for (int i = 0; i < STAGES; i++) tag_q[i] <= '0;
        end else begin
            done_q         <= 1'b0;
            tag_q[0].valid <= issue;
            tag_q[0].addr  <= TAG_AW'(addr_q);
            tag_q[0].x     <= TAG_XW'(x_q);
            tag_q[0].y     <= TAG_YW'(y_q);
            for (int i = 1; i < STAGES; i++) tag_q[i] <= tag_q[i-1];
            if (tag_q[0].valid) begin
                luma_q <= pix_y_i;
                cb_q   <= pix_cb_i;
                cr_q   <= pix_cr_i;
            end
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        state_q  <= ST_SCAN;
                        bgdiff_q <= bg_diff_en_i;
                        x_q      <= '0;
                        y_q      <= '0;
                        addr_q   <= '0;
                    end
                end
                ST_SCAN: begin
                    if (!pause_i) begin
                        addr_q <= addr_q + 1'b1;
                        if (x_q == X_LAST) begin
                            x_q <= '0;
                            y_q <= y_q + 1'b1;
                        end else begin
                            x_q <= x_q + 1'b1;
                        end
                        if (addr_q == ADDR_LAST) state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!upstream_busy) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    bbox_accum #(.XW(XW), .YW(YW), .CW(CW)) u_accum (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (acc_clr),
        .upd_i   (acc_upd),
        .pub_i   (publish),
        .x_i     (XW'(tag_q[STAGES-1].x)),
        .y_i     (YW'(tag_q[STAGES-1].y)),
        .count_o (skin_count_o),
        .xmin_o  (bbox_xmin_o),
        .xmax_o  (bbox_xmax_o),
        .ymin_o  (bbox_ymin_o),
        .ymax_o  (bbox_ymax_o),
        .valid_o (bbox_valid_o)
    );

    assign pix_rd_o     = issue;
    assign pix_addr_o   = addr_q;
    assign dec_luma_o   = luma_q;
    assign dec_cb_o     = cb_q;
    assign dec_cr_o     = cr_q;
    assign dec_bgdiff_o = bgdiff_q;
    assign mask_we_o    = tag_q[STAGES-1].valid;
    assign mask_addr_o  = ADDR_W'(tag_q[STAGES-1].addr);
    assign mask_bit_o   = tag_q[STAGES-1].valid & dec_obj_i;
    assign busy_o       = (state_q != ST_IDLE);
    assign done_o       = done_q;

endmodule

// File: tb/tb_skin_scan_ctrl.sv
// Directed bench for skin_scan_ctrl on a 4x3 frame with a 1-cycle RAM and decider model.
module tb_skin_scan_ctrl;

    logic       clk = 1'b0, rst = 1'b0, start = 1'b0, bg_diff_en = 1'b0, pause = 1'b0;
    logic       pix_rd, dec_bgdiff, mask_we, mask_bit, busy, done, bbox_valid;
    logic [3:0] pix_addr, mask_addr, skin_count;
    logic [7:0] pix_y = 8'd0, pix_cb = 8'd0, pix_cr = 8'd0;
    logic [7:0] dec_luma, dec_cb, dec_cr;
    logic       dec_obj = 1'b0;
    logic [1:0] bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax;

    logic [7:0] mem [16];
    int         cyc = 0, n_chk = 0, n_err = 0;
    logic [3:0] rd_addr[$], mw_addr[$];
    int         rd_cyc[$], mw_cyc[$];
    logic       mw_bit[$];
    int         done_cnt, done_cyc, busy_rise, busy_fall, bg_bad;
    logic       exp_bg = 1'b0, busy_prev = 1'b0;
    int         c;

    skin_scan_ctrl #(.IMG_W(4), .IMG_H(3), .DEC_LAT(1), .ADDR_W(4)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .bg_diff_en_i(bg_diff_en), .pause_i(pause),
        .pix_rd_o(pix_rd), .pix_addr_o(pix_addr),
        .pix_y_i(pix_y), .pix_cb_i(pix_cb), .pix_cr_i(pix_cr),
        .dec_luma_o(dec_luma), .dec_cb_o(dec_cb), .dec_cr_o(dec_cr), .dec_bgdiff_o(dec_bgdiff),
        .dec_obj_i(dec_obj),
        .mask_we_o(mask_we), .mask_addr_o(mask_addr), .mask_bit_o(mask_bit),
        .busy_o(busy), .done_o(done), .skin_count_o(skin_count),
        .bbox_xmin_o(bbox_xmin), .bbox_xmax_o(bbox_xmax),
        .bbox_ymin_o(bbox_ymin), .bbox_ymax_o(bbox_ymax), .bbox_valid_o(bbox_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (pix_rd) begin
            pix_y  <= mem[pix_addr];
            pix_cb <= mem[pix_addr] ^ 8'h55;
            pix_cr <= mem[pix_addr] ^ 8'hAA;
        end
    end

    // Decider: one register stage, luma >= 128 means skin.
    always @(posedge clk) dec_obj <= (dec_luma >= 8'd128);

    always @(negedge clk) begin
        if (pix_rd === 1'b1) begin
            rd_addr.push_back(pix_addr);
            rd_cyc.push_back(cyc);
        end
        if (mask_we === 1'b1) begin
            mw_addr.push_back(mask_addr);
            mw_bit.push_back(mask_bit);
            mw_cyc.push_back(cyc);
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (busy === 1'b1 && busy_prev === 1'b0) busy_rise = cyc;
        if (busy === 1'b0 && busy_prev === 1'b1) busy_fall = cyc;
        if (busy === 1'b1 && dec_bgdiff !== exp_bg) bg_bad++;
        busy_prev = busy;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [11:0] m);
        for (int i = 0; i < 16; i++) begin
            mem[i] = 8'd10;
            if (i < 12) begin
                if (m[i]) mem[i] = 8'd200;
            end
        end
    endtask

    // Starts a frame; p0/plen = pause window, s2 = extra start, roff = reset cycle (offsets from c).
    task automatic run_frame(input logic bg, input int p0, input int plen, input int s2,
                             input int roff, input int max_k, output int c0);
        int tail;
        rd_addr.delete(); rd_cyc.delete();
        mw_addr.delete(); mw_bit.delete(); mw_cyc.delete();
        done_cnt = 0; done_cyc = -1; busy_rise = -1; busy_fall = -1; bg_bad = 0;
        exp_bg = bg;
        tail = 0;
        bg_diff_en = bg;
        start = 1'b1;
        c0 = cyc;
        step();
        start = 1'b0;
        bg_diff_en = ~bg;
        for (int k = 1; k <= max_k; k++) begin
            pause = (k >= p0 && k < p0 + plen);
            start = (k == s2);
            rst   = (k != roff);
            step();
            if (done_cnt > 0) tail++;
            if (tail >= 3) break;
        end
        pause = 1'b0;
        start = 1'b0;
        rst   = 1'b1;
        bg_diff_en = 1'b0;
    endtask

    task automatic check_full(input string nm, input int c0, input int d);
        int bad;
        chk({nm, "_rd_n"}, rd_addr.size(), 12);
        chk({nm, "_rd_first"}, rd_cyc[0], c0 + 1);
        chk({nm, "_rd_last"}, rd_cyc[rd_cyc.size()-1], c0 + 12 + d);
        bad = 0;
        foreach (rd_addr[i]) if (int'(rd_addr[i]) != i) bad++;
        chk({nm, "_rd_seq"}, bad, 0);
        chk({nm, "_mw_n"}, mw_addr.size(), 12);
        chk({nm, "_mw_first"}, mw_cyc[0], c0 + 4);
        chk({nm, "_mw_last"}, mw_cyc[mw_cyc.size()-1], c0 + 15 + d);
        bad = 0;
        foreach (mw_addr[i]) if (int'(mw_addr[i]) != i) bad++;
        chk({nm, "_mw_seq"}, bad, 0);
        chk({nm, "_done_n"}, done_cnt, 1);
        chk({nm, "_done_cyc"}, done_cyc, c0 + 16 + d);
        chk({nm, "_busy_rise"}, busy_rise, c0 + 1);
        chk({nm, "_busy_fall"}, busy_fall, c0 + 17 + d);
        chk({nm, "_bg"}, bg_bad, 0);
    endtask

    task automatic check_res(input string nm, input int cnt, input int x0, input int x1,
                             input int y0, input int y1, input int v);
        int s;
        chk({nm, "_count"}, skin_count, cnt);
        chk({nm, "_xmin"}, bbox_xmin, x0);
        chk({nm, "_xmax"}, bbox_xmax, x1);
        chk({nm, "_ymin"}, bbox_ymin, y0);
        chk({nm, "_ymax"}, bbox_ymax, y1);
        chk({nm, "_valid"}, bbox_valid, v);
        s = 0;
        foreach (mw_bit[i]) s += int'(mw_bit[i]);
        chk({nm, "_mask_ones"}, s, cnt);
    endtask

    initial begin
        load(12'hFFF);
        // Reset behaviour
        rst = 1'b0;
        step(); step();
        chk("rst_flags", int'({pix_rd, busy, done, mask_we, mask_bit, dec_bgdiff, bbox_valid}), 0);
        chk("rst_addr", int'({pix_addr, mask_addr}), 0);
        chk("rst_stats", int'({skin_count, bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax}), 0);
        chk("rst_dec", int'({dec_luma, dec_cb, dec_cr}), 0);
        rd_addr.delete();
        start = 1'b1;
        step(); step(); step();
        start = 1'b0;
        chk("rst_start_rd", rd_addr.size(), 0);
        chk("rst_start_busy", int'(busy), 0);
        rst = 1'b1;
        step(); step();

        // All-skin frame
        load(12'hFFF);
        run_frame(1'b0, 0, 0, -1, -1, 60, c);
        check_full("all", c, 0);
        check_res("all", 12, 0, 3, 0, 2, 1);

        // Single skin pixel at addr 6 -> (x=2, y=1)
        load(12'h040);
        run_frame(1'b0, 0, 0, -1, -1, 60, c);
        check_full("one", c, 0);
        check_res("one", 1, 2, 2, 1, 1, 1);
        chk("one_bit6", int'(mw_bit[6]), 1);

        // No skin, background difference enabled
        load(12'h000);
        run_frame(1'b1, 0, 0, -1, -1, 60, c);
        check_full("none", c, 0);
        check_res("none", 0, 0, 0, 0, 0, 0);
        chk("none_bgdiff", int'(dec_bgdiff), 1);

        // Pause for 3 cycles while addr 5 is pending
        load(12'hFFF);
        run_frame(1'b0, 6, 3, -1, -1, 60, c);
        check_full("pause", c, 3);
        chk("pause_addr5_cyc", rd_cyc[5], c + 9);
        chk("pause_addr4_cyc", rd_cyc[4], c + 5);
        check_res("pause", 12, 0, 3, 0, 2, 1);

        // Second start during SCAN must be ignored
        load(12'h810);
        run_frame(1'b0, 0, 0, 5, -1, 60, c);
        check_full("restart", c, 0);
        step(); step(); step();
        chk("restart_done_n", done_cnt, 1);
        chk("restart_rd_n", rd_addr.size(), 12);
        check_res("restart", 2, 0, 3, 1, 2, 1);

        // Reset while addr 7 is issued
        load(12'hFFF);
        run_frame(1'b0, 0, 0, -1, 8, 14, c);
        chk("abort_busy_fall", busy_fall, c + 9);
        chk("abort_mw_n", mw_addr.size(), 5);
        chk("abort_mw_last", mw_cyc[mw_cyc.size()-1], c + 8);
        chk("abort_rd_n", rd_addr.size(), 8);
        chk("abort_done_n", done_cnt, 0);
        chk("abort_count", int'(skin_count), 0);

        // Fresh frame after the abort
        load(12'hFFF);
        run_frame(1'b0, 0, 0, -1, -1, 60, c);
        check_full("fresh", c, 0);
        check_res("fresh", 12, 0, 3, 0, 2, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/skin_scan_ctrl.md
Name: skin_scan_ctrl

Overview:
Frame-scan sequencer for the SkinDecider datapath. On a start pulse it walks a stored YCbCr frame in raster order and streams one pixel per cycle into SkinDecider. It writes the returned object bit to a binary mask memory and accumulates per-frame skin statistics: pixel count and bounding box. These statistics feed the downstream gesture-recognition stages.

Parameters:
IMG_W, 160, frame width in pixels
IMG_H, 120, frame height in pixels
DEC_LAT, 1, SkinDecider latency in cycles, inputs to object_image
ADDR_W, 15, pixel/mask address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-low (rst=0 resets on the clk edge)
start  in  1  one-cycle request to scan a frame
bg_diff_en  in  1  background-difference enable, latched at start
pause  in  1  holds pixel issue while high
pix_rd  out  1  frame-buffer read strobe
pix_addr  out  ADDR_W  frame-buffer read address (raster y*IMG_W+x)
pix_y, pix_cb, pix_cr  in  8 each  read data, valid the cycle after pix_rd
dec_luma, dec_cb, dec_cr  out  8 each  to SkinDecider luma_ch/cb_ch/cr_ch
dec_bgdiff  out  1  to SkinDecider BACKGROUND_DIFFERENCE
dec_obj  in  1  from SkinDecider object_image
mask_we  out  1  mask write strobe
mask_addr  out  ADDR_W  mask write address
mask_bit  out  1  mask write data (dec_obj)
busy  out  1  high from the cycle after start acceptance until done
done  out  1  one-cycle frame-complete pulse
skin_count  out  clog2(IMG_W*IMG_H+1)  skin pixels in the last frame
bbox_xmin, bbox_xmax  out  clog2(IMG_W)  bounding-box columns
bbox_ymin, bbox_ymax  out  clog2(IMG_H)  bounding-box rows
bbox_valid  out  1  high if the last frame contained at least one skin pixel

Behaviour:
- Reset: every output is 0, the FSM goes to IDLE, and the pipeline valid bits clear. Reset mid-frame aborts the scan immediately and issues no further mask writes.
- FSM states: IDLE, SCAN, DRAIN, DONE.
  - IDLE: on start=1, go to SCAN. Latch bg_diff_en into dec_bgdiff, held constant for the whole frame. Clear the accumulators and zero the x, y and address counters.
  - SCAN: each cycle with pause=0, assert pix_rd with the current address and advance x/y/addr. x wraps to 0 at IMG_W-1 and y increments. Use counters only, no multiplier. With pause=1, pix_rd=0 and the counters hold; in-flight pixels continue. After issuing addr IMG_W*IMG_H-1, go to DRAIN.
  - DRAIN: wait until the pipeline valid bits are all 0, then go to DONE.
  - DONE: done=1 for one cycle. Publish skin_count, bbox and bbox_valid. Return to IDLE.
- start while busy: ignored.
- Result outputs: hold their values until the next DONE.
- Pipeline, per pixel issued in cycle t:
  - t+1: pix_* valid, registered into dec_*.
  - t+2: dec_* presented to the decider.
  - t+2+DEC_LAT: dec_obj sampled. mask_we=1, mask_addr=that pixel's address, mask_bit=dec_obj.
  - A valid/addr/x/y delay line of 2+DEC_LAT stages carries the pixel tag.
- Throughput: one pixel per cycle when unpaused.
- Accumulation: when mask_we=1 and dec_obj=1, increment count. On the first skin pixel of a frame, load min=max=(x,y). Afterwards, update min/max with unsigned compares.
- No-skin frame: skin_count=0, bbox_valid=0, and all bbox outputs are 0.
- dec_* hold their last value when no valid pixel is in flight.

Decomposition:
- Shared package `skin_pkg`: FSM state encoding, a pixel tag struct (valid, addr, x, y), and width constants derived from IMG_W/IMG_H.
- Sub-module `bbox_accum`: count plus min/max tracker, with clear, update and publish inputs.

Test Plan:
- Bench setup for all scenarios: IMG_W=4, IMG_H=3, DEC_LAT=1. A behavioural 1-cycle RAM supplies pix_*; a decider model returns a programmable object bit.
- Reset: drive rst=0 for 2 cycles -> all outputs 0. start with rst=0 -> no pix_rd.
- All-skin frame, start in cycle c:
  - pix_rd in c+1..c+12 with addr 0..11.
  - mask_we in c+4..c+15 with addr 0..11.
  - done at c+16.
  - skin_count=12, bbox=(0,0)-(3,2), bbox_valid=1.
- Single skin pixel at addr 6 -> skin_count=1, bbox xmin=xmax=2, ymin=ymax=1, bbox_valid=1. mask_bit=1 only at addr 6.
- No skin, with bg_diff_en=1 at start -> dec_bgdiff=1 through the frame. skin_count=0, bbox_valid=0, bbox all 0.
- Pause held 3 cycles while addr 5 is pending -> pix_rd low 3 cycles, then addr 5 issued. Mask addresses stay consecutive with no duplicates. done delayed by exactly 3 cycles.
- Second start during SCAN -> ignored, single done.
- rst=0 at addr 7 -> idle next cycle, no further mask_we. A fresh start then produces a full correct frame.
